vga_timing_pattern_gen: RTL and testbench
=========================================

Name: vga_timing_pattern_gen

Overview:
- Parametrised successor to the fixed 640x480 screen_design block.
- Generates VGA sync timing from any front-porch/sync/back-porch set, with programmable sync polarity and a pixel-clock enable.
- Drives COLOR_W-bit RGB from four selectable test patterns; mode changes are frame-synchronous.
- Sits between the board clock and the VGA DAC/pins; also used as the timing master for later framebuffer readers (de, px_x, px_y, frame_start).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of h_sync (0 = active-low)
VS_POL, 0, asserted level of v_sync
COLOR_W, 4, bits per colour channel
CNT_W, 11, width of the internal counters and the px_x/px_y outputs

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
pix_en  in  1  pixel-tick enable; timing advances only on cycles where it is high
mode_in  in  2  requested pattern
mode_wr  in  1  one-cycle strobe that captures mode_in
h_sync  out  1  horizontal sync
v_sync  out  1  vertical sync
r_out  out  COLOR_W  red
g_out  out  COLOR_W  green
b_out  out  COLOR_W  blue
de  out  1  display enable (active region)
px_x  out  CNT_W  x coordinate of the current output pixel
px_y  out  CNT_W  y coordinate of the current output pixel
frame_start  out  1  pulse marking pixel (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must fit in CNT_W bits.
- Counters hc/vc, on each pix_en cycle:
  - hc increments and wraps H_TOTAL-1 -> 0.
  - vc increments only on the hc wrap, and wraps V_TOTAL-1 -> 0.
  - pix_en low: all state and outputs hold.
- Output stage: registered on pix_en, computed from pre-update hc/vc, so outputs lag the counters by exactly one pixel tick. All outputs are mutually aligned.
- h_sync = HS_POL when hc is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~HS_POL. v_sync is the same on vc with the V_* parameters and VS_POL.
- de = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- px_x = hc, px_y = vc, unconditionally (including blanking).
- frame_start = 1 for exactly one pixel tick, when hc == 0 and vc == 0.
- RGB is all-zero whenever de = 0.
- Patterns (active mode):
  - 0, solid: all channels all-ones.
  - 1, 8 vertical bars, BAR_W = H_ACTIVE/8:
    - Order: white, yellow, cyan, green, magenta, red, blue, black; channels are all-ones or zero.
    - Bar index comes from a sub-counter/bar counter pair, cleared when hc == 0; no divider.
    - Pixels at x >= 8*BAR_W use bar 7.
  - 2, checkerboard: white when px_x[5] ^ px_y[5], else black.
  - 3, gradient: r = hc[COLOR_W+4:5], g = vc[COLOR_W+4:5], b = ~r.
- Mode register:
  - mode_wr captures mode_in into mode_pend on any clk edge, independent of pix_en.
  - mode_act <= mode_pend only on the pix_en cycle where hc == 0 and vc == 0, so the new pattern starts on a whole frame.
  - mode_wr in that same cycle: the newly written value is not applied until the next frame.
- Reset (async, immediate):
  - hc, vc, px_x, px_y, bar counters, mode_pend, mode_act all 0.
  - RGB 0, de 0, frame_start 0.
  - h_sync = ~HS_POL, v_sync = ~VS_POL.
  - First pix_en after release outputs pixel (0,0) with frame_start = 1.
  - Reset mid-frame abandons the frame; no partial sync pulse persists.

Test Plan:
- Defaults, pix_en every 4th clk: successive frame_start pulses exactly 420000 pix_en ticks apart; de high 640 ticks per active line.
- h_sync low for exactly 96 ticks at px_x 656..751. v_sync low for lines 490..491 only; both high in all other positions.
- Mode 1: (x=0,y=0) RGB F/F/F; x=80 F/F/0; x=560 0/0/0; x=639 0/0/0; x=640 (blanking) 0/0/0.
- mode_wr=1, mode_in=2 at line 100: mode 1 persists to the end of frame; checkerboard from the next frame_start. (31,0) black, (32,0) white, (32,32) black.
- HS_POL=1, VS_POL=1, H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1: frame = 24*7 = 168 ticks; h_sync high at x 18..20.
- Assert rst at (300,200), hold 3 clks: outputs go to reset values asynchronously; mode_act = 0; frame_start on the first pix_en after release; pix_en low for 10 clks freezes all outputs.

Source files
------------

// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA timing master with four frame-synchronous test patterns.
// All outputs are registered on pix_en from the pre-update hc/vc, so they lag the counters by one pixel tick.
module vga_timing_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 4,
    parameter int CNT_W    = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic [1:0]         mode_in,
    input  logic               mode_wr,
    output logic               h_sync,
    output logic               v_sync,
    output logic [COLOR_W-1:0] r_out,
    output logic [COLOR_W-1:0] g_out,
    output logic [COLOR_W-1:0] b_out,
    output logic               de,
    output logic [CNT_W-1:0]   px_x,
    output logic [CNT_W-1:0]   px_y,
    output logic               frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS     = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE     = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SS     = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE     = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
    localparam logic [COLOR_W-1:0] ONES   = {COLOR_W{1'b1}};

    logic [CNT_W-1:0]   hc_q, hc_d, vc_q, vc_d, sub_q, sub_d;
    logic [2:0]         bar_q, bar_d;
    logic [1:0]         mode_pend_q, mode_pend_d, mode_act_q, mode_act_d, mode_sel;
    logic               origin;

    logic               h_sync_q, h_sync_d, v_sync_q, v_sync_d, de_q, de_d, fs_q, fs_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [CNT_W-1:0]   px_x_q, px_y_q;

    assign origin = (hc_q == '0) && (vc_q == '0);
    // The frame-origin pixel already shows the pending mode, so a switch covers the whole frame.
    assign mode_sel = origin ? mode_pend_q : mode_act_q;

    always_comb begin
        hc_d        = hc_q;
        vc_d        = vc_q;
        sub_d       = sub_q;
        bar_d       = bar_q;
        mode_act_d  = mode_act_q;
        mode_pend_d = mode_wr ? mode_in : mode_pend_q;
        if (pix_en) begin
            if (hc_q == H_LAST) begin
                hc_d  = '0;
                vc_d  = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
                sub_d = '0;
                bar_d = '0;
            end else begin
                hc_d = hc_q + 1'b1;
                // Bar index tracks hc without a divider; it saturates on bar 7 past 8*BAR_W.
                if (sub_q == BAR_LAST) begin
                    sub_d = '0;
                    if (bar_q != 3'd7)
                        bar_d = bar_q + 3'd1;
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
            if (origin)
                mode_act_d = mode_pend_q;
        end
    end

    always_comb begin
        de_d     = (hc_q < H_ACT) && (vc_q < V_ACT);
        h_sync_d = (hc_q >= H_SS && hc_q <= H_SE) ? HS_POL : ~HS_POL;
        v_sync_d = (vc_q >= V_SS && vc_q <= V_SE) ? VS_POL : ~VS_POL;
        fs_d     = origin;
        r_d      = '0;
        g_d      = '0;
        b_d      = '0;
        if (de_d) begin
            unique case (mode_sel)
                2'd0: begin
                    r_d = ONES;
                    g_d = ONES;
                    b_d = ONES;
                end
                2'd1: begin
                    // White, yellow, cyan, green, magenta, red, blue, black.
                    r_d = {COLOR_W{~bar_q[1]}};
                    g_d = {COLOR_W{~bar_q[2]}};
                    b_d = {COLOR_W{~bar_q[0]}};
                end
                2'd2: begin
                    if (hc_q[5] ^ vc_q[5]) begin
                        r_d = ONES;
                        g_d = ONES;
                        b_d = ONES;
                    end
                end
                default: begin
                    r_d = hc_q[COLOR_W+4:5];
                    g_d = vc_q[COLOR_W+4:5];
                    b_d = ~hc_q[COLOR_W+4:5];
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q        <= '0;
            vc_q        <= '0;
            sub_q       <= '0;
            bar_q       <= '0;
            mode_pend_q <= '0;
            mode_act_q  <= '0;
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            sub_q       <= sub_d;
            bar_q       <= bar_d;
            mode_pend_q <= mode_pend_d;
            mode_act_q  <= mode_act_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_sync_q <= ~HS_POL;
            v_sync_q <= ~VS_POL;
            de_q     <= 1'b0;
            fs_q     <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            px_x_q   <= '0;
            px_y_q   <= '0;
        end else if (pix_en) begin
            h_sync_q <= h_sync_d;
            v_sync_q <= v_sync_d;
            de_q     <= de_d;
            fs_q     <= fs_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            px_x_q   <= hc_q;
            px_y_q   <= vc_q;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign r_out       = r_q;
    assign g_out       = g_q;
    assign b_out       = b_q;
    assign px_x        = px_x_q;
    assign px_y        = px_y_q;
endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench: three geometries (default, medium, tiny active-high sync) share one random stimulus
// stream and are compared against an arithmetic pixel-index reference model.
module tb_vga_timing_pattern_gen;
    typedef logic [37:0] vec_t;

    localparam int HA_C [3] = '{640, 128, 16};
    localparam int HF_C [3] = '{16, 8, 2};
    localparam int HS_C [3] = '{96, 12, 3};
    localparam int HB_C [3] = '{48, 12, 3};
    localparam int VA_C [3] = '{480, 48, 4};
    localparam int VF_C [3] = '{10, 3, 1};
    localparam int VS_C [3] = '{2, 2, 1};
    localparam int VB_C [3] = '{33, 5, 1};
    localparam bit HP_C [3] = '{1'b0, 1'b0, 1'b1};
    localparam bit VP_C [3] = '{1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b0;
    logic [1:0] mode_in = 2'd0;
    logic       mode_wr = 1'b0;

    logic        hs [3];
    logic        vs [3];
    logic        de [3];
    logic        fs [3];
    logic [3:0]  r [3];
    logic [3:0]  g [3];
    logic [3:0]  b [3];
    logic [10:0] px [3];
    logic [10:0] py [3];
    vec_t        obs [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        vga_timing_pattern_gen #(
            .H_ACTIVE(HA_C[gi]), .H_FP(HF_C[gi]), .H_SYNC(HS_C[gi]), .H_BP(HB_C[gi]),
            .V_ACTIVE(VA_C[gi]), .V_FP(VF_C[gi]), .V_SYNC(VS_C[gi]), .V_BP(VB_C[gi]),
            .HS_POL(HP_C[gi]), .VS_POL(VP_C[gi]), .COLOR_W(4), .CNT_W(11)
        ) u_dut (
            .clk(clk), .rst(rst), .pix_en(pix_en), .mode_in(mode_in), .mode_wr(mode_wr),
            .h_sync(hs[gi]), .v_sync(vs[gi]), .r_out(r[gi]), .g_out(g[gi]), .b_out(b[gi]),
            .de(de[gi]), .px_x(px[gi]), .px_y(py[gi]), .frame_start(fs[gi])
        );
    end

    always_comb begin
        for (int c = 0; c < 3; c++)
            obs[c] = {hs[c], vs[c], de[c], fs[c], r[c], g[c], b[c], px[c], py[c]};
    end

    int         n_vec = 0;
    int         n_err = 0;
    int         k [3];
    int         cur_x [3];
    int         cur_y [3];
    int         cur_f [3];
    logic [1:0] pend [3];
    logic [1:0] act [3];
    vec_t       exp_v [3];

    function automatic int ht(input int c);
        return HA_C[c] + HF_C[c] + HS_C[c] + HB_C[c];
    endfunction

    function automatic int ft(input int c);
        return ht(c) * (VA_C[c] + VF_C[c] + VS_C[c] + VB_C[c]);
    endfunction

    function automatic vec_t reset_vec(input int c);
        return {~HP_C[c], ~VP_C[c], 36'd0};
    endfunction

    // Reference pixel: pure arithmetic on (x, y) and the mode in force for the frame.
    function automatic vec_t model_pixel(input int c, input int x, input int y, input logic [1:0] m);
        logic [2:0] bar_rgb [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        logic h, v, d, f;
        logic [3:0] rr, gg, bb;
        int bar;
        d  = (x < HA_C[c]) && (y < VA_C[c]);
        h  = (x >= HA_C[c] + HF_C[c] && x < HA_C[c] + HF_C[c] + HS_C[c]) ? HP_C[c] : ~HP_C[c];
        v  = (y >= VA_C[c] + VF_C[c] && y < VA_C[c] + VF_C[c] + VS_C[c]) ? VP_C[c] : ~VP_C[c];
        f  = (x == 0) && (y == 0);
        rr = 4'h0;
        gg = 4'h0;
        bb = 4'h0;
        if (d) begin
            case (m)
                2'd0: begin rr = 4'hF; gg = 4'hF; bb = 4'hF; end
                2'd1: begin
                    bar = x / (HA_C[c] / 8);
                    if (bar > 7) bar = 7;
                    rr = {4{bar_rgb[bar][2]}};
                    gg = {4{bar_rgb[bar][1]}};
                    bb = {4{bar_rgb[bar][0]}};
                end
                2'd2: if (((x / 32) + (y / 32)) % 2 == 1) begin rr = 4'hF; gg = 4'hF; bb = 4'hF; end
                default: begin
                    rr = 4'((x / 32) % 16);
                    gg = 4'((y / 32) % 16);
                    bb = 4'(15 - (x / 32) % 16);
                end
            endcase
        end
        return {h, v, d, f, rr, gg, bb, 11'(x), 11'(y)};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            k[c] = 0; pend[c] = 2'd0; act[c] = 2'd0;
            exp_v[c] = reset_vec(c);
            cur_x[c] = -1; cur_y[c] = -1; cur_f[c] = -1;
        end
    endtask

    // One clock: drive inputs, advance the model by the edge, settle 1 time unit past the edge.
    task automatic step(input logic pe, input logic wr, input logic [1:0] mi);
        int p;
        pix_en = pe; mode_wr = wr; mode_in = mi;
        @(posedge clk);
        if (!rst) begin
            for (int c = 0; c < 3; c++) begin
                if (pe) begin
                    p = k[c] % ft(c);
                    cur_f[c] = k[c] / ft(c);
                    cur_x[c] = p % ht(c);
                    cur_y[c] = p / ht(c);
                    if (p == 0) act[c] = pend[c];
                    exp_v[c] = model_pixel(c, cur_x[c], cur_y[c], act[c]);
                    k[c]++;
                end
                if (wr) pend[c] = mi;
            end
        end
        #1;
        pix_en = 1'b0; mode_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (obs[c] !== reset_vec(c)) begin
                n_err++;
                $display("FAIL reset_state cfg%0d: got %h want %h", c, obs[c], reset_vec(c));
            end
        end
        rst = 1'b0;
        step(1'b0, 1'b1, 2'd1);
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (obs[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL reset_hold cfg%0d: got %h want %h", c, obs[c], exp_v[c]);
            end
        end
        $display("test_reset done: mode 1 queued for first frame");
    endtask

    task automatic test_bars();
        logic [11:0] want;
        logic pe, hit;
        int guard = 0;
        while (!(cur_y[0] == 0 && cur_x[0] >= 650) && guard < 5000) begin
            pe = ($urandom_range(3) != 0);
            step(pe, 1'b0, 2'd0);
            guard++;
            for (int c = 0; c < 3; c++) begin
                n_vec++;
                if (obs[c] !== exp_v[c]) begin
                    n_err++;
                    $display("FAIL bars_pixel cfg%0d: got %h want %h", c, obs[c], exp_v[c]);
                end
            end
            hit = 1'b0;
            want = 12'h000;
            if (pe && cur_y[0] == 0) begin
                case (cur_x[0])
                    0:   begin hit = 1'b1; want = 12'hFFF; end
                    80:  begin hit = 1'b1; want = 12'hFF0; end
                    560, 639, 640: hit = 1'b1;
                    default: hit = 1'b0;
                endcase
            end
            if (hit) begin
                n_vec++;
                if ({r[0], g[0], b[0]} !== want) begin
                    n_err++;
                    $display("FAIL bars_x%0d: got %h want %h", cur_x[0], {r[0], g[0], b[0]}, want);
                end
            end
        end
        if (guard >= 5000) begin
            n_err++;
            $display("FAIL bars_timeout: got %0d steps want line 0 x>=650", guard);
        end
        $display("test_bars done after %0d clocks", guard);
    endtask

    task automatic test_sync();
        int de_cnt = 0, hs_cnt = 0, hs_first = -1, hs_last = -1;
        int fs_gap = 0, guard = 0;
        logic fs_seen = 1'b0, pe;
        while (cur_y[0] != 2 && guard < 20000) begin
            pe = (guard % 4 == 3);
            step(pe, 1'b0, 2'd0);
            guard++;
            for (int c = 0; c < 3; c++) begin
                n_vec++;
                if (obs[c] !== exp_v[c]) begin
                    n_err++;
                    $display("FAIL sync_pixel cfg%0d: got %h want %h", c, obs[c], exp_v[c]);
                end
            end
            if (pe) begin
                if (cur_y[0] == 1) begin
                    if (de[0]) de_cnt++;
                    if (!hs[0]) begin
                        hs_cnt++;
                        if (hs_first < 0) hs_first = cur_x[0];
                        hs_last = cur_x[0];
                    end
                end
                n_vec++;
                if (hs[2] !== (cur_x[2] >= 18 && cur_x[2] <= 20)) begin
                    n_err++;
                    $display("FAIL tiny_hsync x=%0d: got %b", cur_x[2], hs[2]);
                end
                fs_gap++;
                if (fs[2]) begin
                    if (fs_seen) begin
                        n_vec++;
                        if (fs_gap != 168) begin
                            n_err++;
                            $display("FAIL tiny_frame_period: got %0d want 168", fs_gap);
                        end
                    end
                    fs_seen = 1'b1;
                    fs_gap = 0;
                end
            end
        end
        n_vec += 4;
        if (guard >= 20000) begin n_err++; $display("FAIL sync_timeout: got %0d clocks", guard); end
        if (de_cnt != 640) begin n_err++; $display("FAIL line_de_count: got %0d want 640", de_cnt); end
        if (hs_cnt != 96) begin n_err++; $display("FAIL hsync_width: got %0d want 96", hs_cnt); end
        if (hs_first != 656 || hs_last != 751) begin
            n_err++;
            $display("FAIL hsync_window: got %0d..%0d want 656..751", hs_first, hs_last);
        end
        $display("test_sync done: de=%0d hs_low=%0d at %0d..%0d", de_cnt, hs_cnt, hs_first, hs_last);
    endtask

    task automatic test_mode_switch();
        logic [11:0] want;
        logic pe, wr, hit, b2b_done = 1'b0;
        logic [1:0] mi;
        int guard = 0, hits = 0;
        while (!(cur_f[1] == 0 && cur_y[1] == 40) && guard < 20000) begin
            step($urandom_range(3) != 0, 1'b0, 2'd0);
            guard++;
        end
        step(1'b1, 1'b1, 2'd2);
        while (!(cur_f[1] == 2 && cur_y[1] >= 41) && guard < 60000) begin
            pe = ($urandom_range(3) != 0);
            wr = 1'b0;
            mi = 2'(($urandom_range(3)));
            // Write lands on the very tick that outputs pixel (0,0) of frame 1.
            if (pe && !b2b_done && k[1] > 0 && k[1] % ft(1) == 0) begin
                wr = 1'b1; mi = 2'd3; b2b_done = 1'b1;
            end
            step(pe, wr, mi);
            guard++;
            for (int c = 0; c < 3; c++) begin
                n_vec++;
                if (obs[c] !== exp_v[c]) begin
                    n_err++;
                    $display("FAIL mode_pixel cfg%0d: got %h want %h", c, obs[c], exp_v[c]);
                end
            end
            hit = 1'b0;
            want = 12'h000;
            if (pe) begin
                if (cur_f[1] == 0 && cur_x[1] == 0 && cur_y[1] == 47) begin hit = 1'b1; want = 12'hFFF; end
                if (cur_f[1] == 1 && cur_y[1] == 0 && (cur_x[1] == 0 || cur_x[1] == 31)) hit = 1'b1;
                if (cur_f[1] == 1 && cur_y[1] == 0 && cur_x[1] == 32) begin hit = 1'b1; want = 12'hFFF; end
                if (cur_f[1] == 1 && cur_y[1] == 32 && cur_x[1] == 32) hit = 1'b1;
                if (cur_f[1] == 2 && cur_y[1] == 0 && cur_x[1] == 0) begin hit = 1'b1; want = 12'h00F; end
                if (cur_f[1] == 2 && cur_y[1] == 40 && cur_x[1] == 40) begin hit = 1'b1; want = 12'h11E; end
            end
            if (hit) begin
                hits++;
                n_vec++;
                if ({r[1], g[1], b[1]} !== want) begin
                    n_err++;
                    $display("FAIL mode_point f%0d (%0d,%0d): got %h want %h",
                             cur_f[1], cur_x[1], cur_y[1], {r[1], g[1], b[1]}, want);
                end
            end
        end
        n_vec++;
        if (guard >= 60000 || !b2b_done || hits != 7) begin
            n_err++;
            $display("FAIL mode_coverage: got clocks=%0d b2b=%b hits=%0d want hits=7", guard, b2b_done, hits);
        end
        $display("test_mode_switch done: %0d clocks, %0d point checks", guard, hits);
    endtask

    task automatic test_reset_mid();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (obs[c] !== reset_vec(c)) begin
                n_err++;
                $display("FAIL async_reset cfg%0d: got %h want %h", c, obs[c], reset_vec(c));
            end
        end
        repeat (3) step($urandom_range(1) == 1, 1'b0, 2'd0);
        rst = 1'b0;
        repeat (10) begin
            step(1'b0, 1'b0, 2'd0);
            for (int c = 0; c < 3; c++) begin
                n_vec++;
                if (obs[c] !== reset_vec(c)) begin
                    n_err++;
                    $display("FAIL post_reset_freeze cfg%0d: got %h want %h", c, obs[c], reset_vec(c));
                end
            end
        end
        step(1'b1, 1'b0, 2'd0);
        n_vec++;
        if (fs[1] !== 1'b1 || {r[1], g[1], b[1]} !== 12'hFFF) begin
            n_err++;
            $display("FAIL first_tick: got fs=%b rgb=%h want fs=1 rgb=fff", fs[1], {r[1], g[1], b[1]});
        end
        repeat (30) begin
            step($urandom_range(3) != 0, 1'b0, 2'd0);
            for (int c = 0; c < 3; c++) begin
                n_vec++;
                if (obs[c] !== exp_v[c]) begin
                    n_err++;
                    $display("FAIL restart_pixel cfg%0d: got %h want %h", c, obs[c], exp_v[c]);
                end
            end
        end
        repeat (10) begin
            step(1'b0, 1'b0, 2'd0);
            for (int c = 0; c < 3; c++) begin
                n_vec++;
                if (obs[c] !== exp_v[c]) begin
                    n_err++;
                    $display("FAIL pix_en_freeze cfg%0d: got %h want %h", c, obs[c], exp_v[c]);
                end
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_bars();
        test_sync();
        test_mode_switch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
